spi_flash_arb: RTL

SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

---
 rtl/spi_flash_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_flash_arb                                                 |
// | Function : Two-master SPI flash arbiter with guarded hand-over and       |
// |            idle-hold timeout.                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_flash_arb #(
    parameter int GAP = 2,
    parameter int TMO = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       sclk0,
    input  logic       sclk1,
    input  logic       cs_n0,
    input  logic       cs_n1,
    input  logic [3:0] qdo0,
    input  logic [3:0] qdo1,
    input  logic [3:0] oe0,
    input  logic [3:0] oe1,
    output logic       sclk,
    output logic       cs_n,
    output logic [3:0] qdo,
    output logic [3:0] oe,
    output logic       busy,
    output logic       tmo_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [3:0] C_GAP_M1 = 4'(GAP - 1);
    localparam bit         C_TMO_EN = (TMO != 0);
    localparam logic [9:0] C_TMO_M1 = C_TMO_EN ? 10'(TMO - 1) : 10'd0;

    state_t     state_q;
    logic       last_q;
    logic [3:0] dead_cnt_q;
    logic [9:0] idle_cnt_q;
    logic [9:0] idle_cnt_d;
    logic       lock0_q;
    logic       lock1_q;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       busy_q;
    logic       tmo_err_q;

    logic       want0;
    logic       want1;
    logic       own_sel1;
    logic       own_req;
    logic       own_csn;
    logic       tmo_hit;

    // A locked-out requester is invisible to arbitration until it drops req.
    assign want0    = req0 & ~lock0_q;
    assign want1    = req1 & ~lock1_q;

    assign own_sel1 = (state_q == OWN1);
    assign own_req  = own_sel1 ? req1  : req0;
    assign own_csn  = own_sel1 ? cs_n1 : cs_n0;

    assign idle_cnt_d = (idle_cnt_q == 10'h3FF) ? idle_cnt_q : idle_cnt_q + 10'd1;

    // Fires on the idle cycle whose edge brings the count up to TMO.
    assign tmo_hit  = C_TMO_EN && (idle_cnt_q == C_TMO_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            dead_cnt_q <= 4'd0;
            idle_cnt_q <= 10'd0;
            lock0_q    <= 1'b0;
            lock1_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            if (!req0) lock0_q <= 1'b0;
            if (!req1) lock1_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (want0 && (!want1 || last_q)) begin
                        state_q    <= OWN0;
                        gnt0_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        last_q     <= 1'b0;
                        idle_cnt_q <= 10'd0;
                    end else if (want1) begin
                        state_q    <= OWN1;
                        gnt1_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        last_q     <= 1'b1;
                        idle_cnt_q <= 10'd0;
                    end
                end

                OWN0, OWN1: begin
                    if (!own_req && own_csn) begin
                        state_q    <= DEAD;
                        gnt0_q     <= 1'b0;
                        gnt1_q     <= 1'b0;
                        dead_cnt_q <= C_GAP_M1;
                        idle_cnt_q <= 10'd0;
                    end else if (!own_csn) begin
                        // Transaction in flight: ownership held even if req dropped.
                        idle_cnt_q <= 10'd0;
                    end else if (tmo_hit) begin
                        state_q    <= DEAD;
                        gnt0_q     <= 1'b0;
                        gnt1_q     <= 1'b0;
                        tmo_err_q  <= 1'b1;
                        dead_cnt_q <= C_GAP_M1;
                        idle_cnt_q <= 10'd0;
                        if (own_sel1) lock1_q <= 1'b1;
                        else          lock0_q <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end

                DEAD: begin
                    if (dead_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - 4'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign tmo_err = tmo_err_q;

    // Pads follow state_q directly so an async reset parks them at once.
    always_comb begin
        sclk = 1'b0;
        cs_n = 1'b1;
        qdo  = 4'd0;
        oe   = 4'd0;
        case (state_q)
            OWN0: begin
                sclk = sclk0;
                cs_n = cs_n0;
                qdo  = qdo0;
                oe   = oe0;
            end
            OWN1: begin
                sclk = sclk1;
                cs_n = cs_n1;
                qdo  = qdo1;
                oe   = oe1;
            end
            default: begin
                sclk = 1'b0;
                cs_n = 1'b1;
                qdo  = 4'd0;
                oe   = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
